playlist_controller: RTL and testbench

Top-level playback sequencer for the music player. Replaces the fixed 4-song next/play controller with a playlist controller that supports next, previous, three repeat modes and a timed silent gap between songs. It drives the song reader through `play`, `reset_player` and `song`, and consumes the reader's `song_done`. Button inputs arrive already debounced and one-pulsed.

---
 rtl/playlist_controller.sv | 129 ++++++++++++
 tb/tb_playlist_controller.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/playlist_controller.sv
// Playlist sequencer for the song reader: next/prev, repeat modes, timed gap between songs.
// state     | meaning
// S_IDLE    | paused/stopped, play low
// S_PLAYING | song reader running
// S_RESET   | one-cycle restart pulse to the song reader, then go to target
// S_GAP     | silent gap before an auto-advanced song starts
module playlist_controller #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_W     = 2,
  parameter int GAP_CYCLES = 48000,
  parameter int GAP_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_button,
  input  logic              next_button,
  input  logic              prev_button,
  input  logic              mode_button,
  input  logic              song_done,
  output logic              play,
  output logic              reset_player,
  output logic [SONG_W-1:0] song,
  output logic [1:0]        repeat_mode
);

  typedef enum logic [1:0] {S_IDLE, S_PLAYING, S_RESET, S_GAP} state_t;

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [GAP_W-1:0]  GAP_LOAD  = (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

  state_t            state;
  state_t            target;
  logic [GAP_W-1:0]  gap_cnt;
  logic              done_q;
  logic              done_rise;
  logic [SONG_W-1:0] song_next;
  logic [SONG_W-1:0] song_prev;
  logic [1:0]        mode_next;

  assign done_rise = song_done & ~done_q;
  assign song_next = (song == LAST_SONG) ? '0 : song + SONG_W'(1);
  assign song_prev = (song == '0) ? LAST_SONG : song - SONG_W'(1);

  // a stray mode value of 3 behaves as OFF and wraps back to 0
  always_comb begin
    mode_next = 2'd0;
    case (repeat_mode)
      2'd0:    mode_next = 2'd1;
      2'd1:    mode_next = 2'd2;
      default: mode_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      target       <= S_IDLE;
      song         <= '0;
      repeat_mode  <= 2'd0;
      gap_cnt      <= '0;
      done_q       <= 1'b0;
      play         <= 1'b0;
      reset_player <= 1'b0;
    end else begin
      done_q       <= song_done;
      reset_player <= 1'b0;
      if (mode_button) repeat_mode <= mode_next;
      case (state)
        S_RESET: begin
          case (target)
            S_IDLE: state <= S_IDLE;
            S_GAP: begin
              if (GAP_CYCLES == 0) begin
                state <= S_PLAYING;
                play  <= 1'b1;
              end else begin
                state   <= S_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end
            default: begin
              state <= S_PLAYING;
              play  <= 1'b1;
            end
          endcase
        end
        default: begin
          if (next_button || prev_button) begin
            song         <= next_button ? song_next : song_prev;
            target       <= (state == S_IDLE) ? S_IDLE : S_PLAYING;
            state        <= S_RESET;
            play         <= 1'b0;
            reset_player <= 1'b1;
          end else if (play_button) begin
            if (state == S_IDLE) begin
              state <= S_PLAYING;
              play  <= 1'b1;
            end else begin
              // aborting a gap leaves the reader already rewound
              state <= S_IDLE;
              play  <= 1'b0;
            end
          end else if (state == S_PLAYING && done_rise) begin
            state        <= S_RESET;
            play         <= 1'b0;
            reset_player <= 1'b1;
            if (repeat_mode == 2'd2) begin
              target <= S_GAP;
            end else if (repeat_mode == 2'd1 || song != LAST_SONG) begin
              song   <= song_next;
              target <= S_GAP;
            end else begin
              song   <= '0;
              target <= S_IDLE;
            end
          end else if (state == S_GAP) begin
            if (gap_cnt == '0) begin
              state <= S_PLAYING;
              play  <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_playlist_controller.sv
// Bench for playlist_controller: directed scenarios plus randomized run against a behavioural model.
module tb_playlist_controller;
  localparam int N   = 4;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_button = 1'b0, next_button = 1'b0, prev_button = 1'b0, mode_button = 1'b0;
  logic       song_done = 1'b0;
  logic       play, reset_player;
  logic [1:0] song, repeat_mode;
  logic [3:0] obs;
  logic [3:0] exp;
  int errors = 0;
  int checks = 0;

  assign obs = {play, reset_player, song};

  playlist_controller #(.NUM_SONGS(N), .SONG_W(2), .GAP_CYCLES(GAP), .GAP_W(16)) dut (
    .clk(clk), .reset(reset), .play_button(play_button), .next_button(next_button),
    .prev_button(prev_button), .mode_button(mode_button), .song_done(song_done),
    .play(play), .reset_player(reset_player), .song(song), .repeat_mode(repeat_mode)
  );

  always #5 clk = ~clk;

  // Reference: player phase (stopped, running, restarting, silent) with song index arithmetic mod N
  localparam int PH_STOP = 0, PH_RUN = 1, PH_RESTART = 2, PH_SILENT = 3;
  int m_song = 0, m_mode = 0, m_phase = PH_STOP, m_after = PH_STOP, m_gap_left = 0;
  bit m_done_prev = 0;

  always @(posedge clk or negedge reset) begin
    bit rise;
    int old_mode;
    if (!reset) begin
      m_song = 0; m_mode = 0; m_phase = PH_STOP; m_after = PH_STOP; m_gap_left = 0; m_done_prev = 0;
    end else begin
      rise = song_done && !m_done_prev;
      old_mode = m_mode;
      m_done_prev = song_done;
      if (mode_button) m_mode = (m_mode + 1) % 3;
      if (m_phase == PH_RESTART) begin
        if (m_after == PH_SILENT && GAP == 0) m_phase = PH_RUN;
        else begin
          m_phase = m_after;
          if (m_after == PH_SILENT) m_gap_left = GAP;
        end
      end else if (next_button || prev_button) begin
        m_song  = next_button ? (m_song + 1) % N : (m_song + N - 1) % N;
        m_after = (m_phase == PH_STOP) ? PH_STOP : PH_RUN;
        m_phase = PH_RESTART;
      end else if (play_button) begin
        m_phase = (m_phase == PH_STOP) ? PH_RUN : PH_STOP;
      end else if (m_phase == PH_RUN && rise) begin
        if (old_mode == 2) m_after = PH_SILENT;
        else if (old_mode == 1 || m_song < N - 1) begin
          m_song = (m_song + 1) % N; m_after = PH_SILENT;
        end else begin
          m_song = 0; m_after = PH_STOP;
        end
        m_phase = PH_RESTART;
      end else if (m_phase == PH_SILENT) begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = PH_RUN;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input int b);
    case (b)
      0: play_button = 1'b1;
      1: next_button = 1'b1;
      2: prev_button = 1'b1;
      default: mode_button = 1'b1;
    endcase
    tick();
    {play_button, next_button, prev_button, mode_button} = 4'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    exp = 4'b0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", obs, exp); end
    checks++;
    if (repeat_mode !== 2'd0) begin errors++; $display("FAIL reset_mode got=%0d exp=0", repeat_mode); end
    tick(); tick();
    reset = 1'b1;
    tick();
    exp = 4'b0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL idle_after_reset got=%b exp=%b", obs, exp); end
    pulse(0);
    exp = 4'b1000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL play_start got=%b exp=%b", obs, exp); end
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL play_hold got=%b exp=%b", obs, exp); end
  endtask

  task automatic test_next_prev();
    int btn[5] = '{1, 1, 2, 2, 2};
    logic [3:0] rst_exp[5] = '{4'b0101, 4'b0110, 4'b0101, 4'b0100, 4'b0111};
    for (int i = 0; i < 5; i++) begin
      pulse(btn[i]);
      exp = rst_exp[i]; checks++;
      if (obs !== exp) begin errors++; $display("FAIL skip_reset[%0d] got=%b exp=%b", i, obs, exp); end
      tick();
      exp = {2'b10, rst_exp[i][1:0]}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL skip_resume[%0d] got=%b exp=%b", i, obs, exp); end
    end
  endtask

  task automatic test_gap_all();
    pulse(3);
    checks++;
    if (repeat_mode !== 2'd1) begin errors++; $display("FAIL mode_all got=%0d exp=1", repeat_mode); end
    song_done = 1'b1;
    tick();
    exp = 4'b0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL all_wrap_reset got=%b exp=%b", obs, exp); end
    for (int i = 0; i < GAP; i++) begin
      tick();
      exp = 4'b0000; checks++;
      if (obs !== exp) begin errors++; $display("FAIL all_gap[%0d] got=%b exp=%b", i, obs, exp); end
    end
    for (int i = 0; i < 14; i++) begin
      tick();
      exp = 4'b1000; checks++;
      if (obs !== exp) begin errors++; $display("FAIL all_held_done[%0d] got=%b exp=%b", i, obs, exp); end
    end
    song_done = 1'b0;
    tick();
  endtask

  task automatic test_repeat_off_one();
    pulse(3); pulse(3);
    checks++;
    if (repeat_mode !== 2'd0) begin errors++; $display("FAIL mode_off got=%0d exp=0", repeat_mode); end
    pulse(2); tick();
    song_done = 1'b1;
    tick();
    exp = 4'b0100; checks++;
    if (obs !== exp) begin errors++; $display("FAIL off_last_reset got=%b exp=%b", obs, exp); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = 4'b0000; checks++;
      if (obs !== exp) begin errors++; $display("FAIL off_stop[%0d] got=%b exp=%b", i, obs, exp); end
    end
    song_done = 1'b0;
    pulse(3); pulse(3);
    checks++;
    if (repeat_mode !== 2'd2) begin errors++; $display("FAIL mode_one got=%0d exp=2", repeat_mode); end
    pulse(0);
    pulse(1); tick(); pulse(1); tick();
    exp = 4'b1010; checks++;
    if (obs !== exp) begin errors++; $display("FAIL one_setup got=%b exp=%b", obs, exp); end
    song_done = 1'b1;
    tick();
    exp = 4'b0110; checks++;
    if (obs !== exp) begin errors++; $display("FAIL one_reset got=%b exp=%b", obs, exp); end
    for (int i = 0; i < GAP; i++) begin
      tick();
      exp = 4'b0010; checks++;
      if (obs !== exp) begin errors++; $display("FAIL one_gap[%0d] got=%b exp=%b", i, obs, exp); end
    end
    tick();
    exp = 4'b1010; checks++;
    if (obs !== exp) begin errors++; $display("FAIL one_resume got=%b exp=%b", obs, exp); end
    song_done = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    pulse(2); tick();
    next_button = 1'b1; prev_button = 1'b1; song_done = 1'b1;
    tick();
    next_button = 1'b0; prev_button = 1'b0;
    exp = 4'b0110; checks++;
    if (obs !== exp) begin errors++; $display("FAIL collide_reset got=%b exp=%b", obs, exp); end
    for (int i = 0; i < 4; i++) begin
      tick();
      exp = 4'b1010; checks++;
      if (obs !== exp) begin errors++; $display("FAIL collide_play[%0d] got=%b exp=%b", i, obs, exp); end
    end
    song_done = 1'b0;
    tick();
  endtask

  task automatic test_gap_abort_reset();
    song_done = 1'b1;
    tick(); tick();
    song_done = 1'b0;
    pulse(0);
    for (int i = 0; i < 6; i++) begin
      exp = 4'b0010; checks++;
      if (obs !== exp) begin errors++; $display("FAIL gap_abort[%0d] got=%b exp=%b", i, obs, exp); end
      tick();
    end
    pulse(0);
    exp = 4'b1010; checks++;
    if (obs !== exp) begin errors++; $display("FAIL abort_replay got=%b exp=%b", obs, exp); end
    song_done = 1'b1;
    tick(); tick();
    song_done = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    exp = 4'b0000; checks++;
    if (obs !== exp) begin errors++; $display("FAIL async_reset got=%b exp=%b", obs, exp); end
    checks++;
    if (repeat_mode !== 2'd0) begin errors++; $display("FAIL async_mode got=%0d exp=0", repeat_mode); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset       = ($urandom_range(0, 399) != 0);
      play_button = ($urandom_range(0, 15) == 0);
      next_button = ($urandom_range(0, 19) == 0);
      prev_button = ($urandom_range(0, 19) == 0);
      mode_button = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) song_done = ~song_done;
      tick();
      exp = {m_phase == PH_RUN, m_phase == PH_RESTART, 2'(m_song)}; checks++;
      if (obs !== exp) begin errors++; $display("FAIL rand_obs[%0d] got=%b exp=%b", i, obs, exp); end
      checks++;
      if (repeat_mode !== 2'(m_mode)) begin
        errors++; $display("FAIL rand_mode[%0d] got=%0d exp=%0d", i, repeat_mode, m_mode);
      end
    end
    reset = 1'b1;
    {play_button, next_button, prev_button, mode_button, song_done} = 5'b0;
  endtask

  initial begin
    test_reset();
    test_next_prev();
    test_gap_all();
    test_repeat_off_one();
    test_collision();
    test_gap_abort_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
